// File: rtl/phase_detector.sv
// DPLL front end: measures the reference period and the feedback edge's phase offset
// once per reference period. Define FIN_AVG_EN to average f_in over the last 4 periods.
module phase_detector #(
    parameter int N_BIT       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int MAX_COUNT   = 2**N_BIT - 1
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             f_ref,
    input  logic             f_fb,
    output logic [N_BIT-1:0] diff_1,
    output logic [N_BIT-1:0] diff_2,
    output logic [N_BIT-1:0] f_in,
    output logic             first_second,
    output logic             timeout,
    output logic             ready
);
    localparam logic [N_BIT-1:0] MAX_C = N_BIT'(MAX_COUNT);
    localparam logic [N_BIT-1:0] ONE   = N_BIT'(1);

    typedef enum logic [1:0] {S_SYNC, S_REF, S_FB} state_t;

    // Channel 0 is the reference, channel 1 the feedback clock
    logic [1:0] w_pin;
    logic       w_ref_e;
    logic       w_fb_e;
    assign w_pin = {f_fb, f_ref};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sync
            logic [SYNC_STAGES-1:0] r_sync;
            logic                   r_prev;
            logic                   r_edge;
            always_ff @(posedge Clock) begin
                if (Reset) begin
                    r_sync <= '0;
                    r_prev <= 1'b0;
                    r_edge <= 1'b0;
                end else begin
                    r_sync <= {r_sync[SYNC_STAGES-2:0], w_pin[gi]};
                    r_prev <= r_sync[SYNC_STAGES-1];
                    r_edge <= r_sync[SYNC_STAGES-1] & ~r_prev;
                end
            end
        end
    endgenerate

    assign w_ref_e = g_sync[0].r_edge;
    assign w_fb_e  = g_sync[1].r_edge;

    state_t           r_state, w_state_next;
    logic [N_BIT-1:0] r_cnt, w_cnt_next;
    logic [N_BIT-1:0] r_d1, w_d1_next;
    logic             w_pub, w_pub_to, w_pub_ok;
    logic [N_BIT-1:0] w_p_d1, w_p_d2, w_p_fin, w_fin_pub;
    logic             w_p_fs;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= S_SYNC;
            r_cnt   <= '0;
            r_d1    <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_d1    <= w_d1_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = (r_cnt == MAX_C) ? r_cnt : r_cnt + ONE;
        w_d1_next    = r_d1;
        w_pub        = 1'b0;
        w_pub_to     = 1'b0;
        w_p_d1       = '0;
        w_p_d2       = '0;
        w_p_fin      = '0;
        w_p_fs       = 1'b0;
        case (r_state)
            S_SYNC: begin
                if (w_ref_e) begin
                    w_cnt_next   = '0;
                    w_state_next = S_REF;
                end
            end
            S_REF, S_FB: begin
                if (w_ref_e) begin
                    w_cnt_next   = '0;
                    w_pub        = 1'b1;
                    w_p_fin      = r_cnt;
                    w_state_next = S_REF;
                    if (r_state == S_FB) begin
                        w_p_d1 = r_d1;
                        w_p_d2 = r_cnt - r_d1;
                        w_p_fs = (r_d1 > w_p_d2);
                    end else begin
                        w_p_d1 = r_cnt;
                        w_p_d2 = '0;
                        w_p_fs = 1'b1;
                    end
                end else if (r_cnt == MAX_C) begin
                    w_pub_to     = 1'b1;
                    w_state_next = S_SYNC;
                end else if (w_fb_e && (r_state == S_REF)) begin
                    // cnt trails the strobe offset by one; d1 is the true offset
                    w_d1_next    = r_cnt + ONE;
                    w_state_next = S_FB;
                end
            end
            default: w_state_next = S_SYNC;
        endcase
        // A feedback edge coinciding with the reference edge opens the new period at offset 0
        if (w_ref_e && w_fb_e) begin
            w_d1_next    = '0;
            w_state_next = S_FB;
        end
    end

`ifdef FIN_AVG_EN
    logic [N_BIT-1:0] r_hist [3];
    logic [1:0]       r_nhist;
    logic [N_BIT+1:0] w_sum;

    assign w_sum = (N_BIT+2)'(r_hist[0]) + (N_BIT+2)'(r_hist[1])
                 + (N_BIT+2)'(r_hist[2]) + (N_BIT+2)'(w_p_fin);
    assign w_fin_pub = w_sum[N_BIT+1:2];
    assign w_pub_ok  = w_pub && (r_nhist == 2'd3);

    always_ff @(posedge Clock) begin
        if (Reset || w_pub_to) begin
            r_nhist <= '0;
        end else if (w_pub) begin
            r_hist[0] <= w_p_fin;
            r_hist[1] <= r_hist[0];
            r_hist[2] <= r_hist[1];
            if (r_nhist != 2'd3) r_nhist <= r_nhist + 2'd1;
        end
    end
`else
    assign w_fin_pub = w_p_fin;
    assign w_pub_ok  = w_pub;
`endif

    logic [N_BIT-1:0] r_diff_1, r_diff_2, r_f_in;
    logic             r_first_second, r_timeout, r_ready;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_diff_1       <= '0;
            r_diff_2       <= '0;
            r_f_in         <= '0;
            r_first_second <= 1'b0;
            r_timeout      <= 1'b0;
            r_ready        <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            if (w_pub_to) begin
                r_diff_1       <= '0;
                r_diff_2       <= '0;
                r_f_in         <= MAX_C;
                r_first_second <= 1'b0;
                r_timeout      <= 1'b1;
                r_ready        <= 1'b1;
            end else if (w_pub_ok) begin
                r_diff_1       <= w_p_d1;
                r_diff_2       <= w_p_d2;
                r_f_in         <= w_fin_pub;
                r_first_second <= w_p_fs;
                r_timeout      <= 1'b0;
                r_ready        <= 1'b1;
            end
        end
    end

    assign diff_1       = r_diff_1;
    assign diff_2       = r_diff_2;
    assign f_in         = r_f_in;
    assign first_second = r_first_second;
    assign timeout      = r_timeout;
    assign ready        = r_ready;

endmodule

// File: tb/tb_phase_detector.sv
// Self-checking bench for phase_detector: pin waveforms are built per segment and the
// expected publications are derived from the edge positions in those waveforms.
module tb_phase_detector;
    localparam int N_BIT = 16;
    localparam int SYNC  = 2;
    localparam int MAXC  = 500;

    logic             clk = 1'b0;
    logic             Reset = 1'b1;
    logic             f_ref = 1'b0;
    logic             f_fb = 1'b0;
    logic [N_BIT-1:0] diff_1, diff_2, f_in;
    logic             first_second, timeout, ready;

    phase_detector #(.N_BIT(N_BIT), .SYNC_STAGES(SYNC), .MAX_COUNT(MAXC)) dut (
        .Clock(clk), .Reset(Reset), .f_ref(f_ref), .f_fb(f_fb),
        .diff_1(diff_1), .diff_2(diff_2), .f_in(f_in),
        .first_second(first_second), .timeout(timeout), .ready(ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        int d1;
        int d2;
        int fin;
        int fs;
        int to;
    } ev_t;

    int  n_tests = 0;
    int  n_fail  = 0;
    int  cyc     = 0;
    int  seg_base = 0;
    int  seg_num = 0;
    bit  collecting = 1'b0;
    bit  ref_q[$];
    bit  fb_q[$];
    ev_t obs_q[$];
    ev_t exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (collecting && ready === 1'b1) begin
            ev_t e;
            e.idx = cyc - seg_base;
            e.d1  = int'(diff_1);
            e.d2  = int'(diff_2);
            e.fin = int'(f_in);
            e.fs  = int'(first_second);
            e.to  = int'(timeout);
            obs_q.push_back(e);
            $display("[TB] seg%0d ready@%0d d1=%0d d2=%0d f_in=%0d fs=%0d to=%0d",
                     seg_num, e.idx, e.d1, e.d2, e.fin, e.fs, e.to);
        end
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check_val({tag, "_ready"}, 64'(ready), 0);
        check_val({tag, "_d1"}, 64'(diff_1), 0);
        check_val({tag, "_d2"}, 64'(diff_2), 0);
        check_val({tag, "_fin"}, 64'(f_in), 0);
        check_val({tag, "_fs"}, 64'(first_second), 0);
        check_val({tag, "_to"}, 64'(timeout), 0);
    endtask

    // Reset held 5 cycles with f_ref toggling; everything must read 0 throughout
    task automatic apply_reset();
        @(posedge clk); #1;
        Reset = 1'b1;
        f_fb  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check_zero_outputs($sformatf("rst%0d_c%0d", seg_num, i));
            f_ref = ~f_ref;
        end
        f_ref = 1'b0;
        Reset = 1'b0;
    endtask

    task automatic add_idle(input int n);
        repeat (n) begin
            ref_q.push_back(1'b0);
            fb_q.push_back(1'b0);
        end
    endtask

    // One reference period of p cycles; feedback pulses (2 cycles wide) at lag and lag2, <0 = none
    task automatic add_period(input int p, input int lag, input int lag2);
        for (int i = 0; i < p; i++) begin
            ref_q.push_back(i < p / 2);
            fb_q.push_back((lag >= 0 && i >= lag && i < lag + 2) ||
                           (lag2 >= 0 && i >= lag2 && i < lag2 + 2));
        end
    endtask

    // Reference model: walk the rising edges of the waveforms
    task automatic compute_expected();
        int rr[$];
        int bb[$];
        int len;
        int p;
        int lag;
        ev_t e;
        exp_q.delete();
        len = ref_q.size();
        for (int i = 0; i < len; i++) begin
            if (ref_q[i] && (i == 0 || !ref_q[i-1])) rr.push_back(i);
            if (fb_q[i] && (i == 0 || !fb_q[i-1])) bb.push_back(i);
        end
        for (int k = 0; k < rr.size(); k++) begin
            if (k + 1 < rr.size() && rr[k+1] - rr[k] - 1 <= MAXC) begin
                p   = rr[k+1] - rr[k];
                lag = -1;
                foreach (bb[j])
                    if (lag < 0 && bb[j] >= rr[k] && bb[j] < rr[k+1]) lag = bb[j] - rr[k];
                e.idx = rr[k+1] + SYNC + 2;
                e.fin = p - 1;
                e.to  = 0;
                if (lag < 0) begin
                    e.d1 = p - 1;
                    e.d2 = 0;
                    e.fs = 1;
                end else begin
                    e.d1 = lag;
                    e.d2 = p - 1 - lag;
                    e.fs = (lag > p - 1 - lag) ? 1 : 0;
                end
                if (e.idx < len) exp_q.push_back(e);
            end else if (rr[k] + MAXC + SYNC + 3 < len) begin
                e.idx = rr[k] + MAXC + SYNC + 3;
                e.d1  = 0;
                e.d2  = 0;
                e.fin = MAXC;
                e.fs  = 0;
                e.to  = 1;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic run_segment();
        int n;
        string t;
        obs_q.delete();
        compute_expected();
        for (int i = 0; i < ref_q.size(); i++) begin
            @(posedge clk); #1;
            if (i == 0) begin
                seg_base   = cyc;
                collecting = 1'b1;
            end
            f_ref = ref_q[i];
            f_fb  = fb_q[i];
        end
        @(negedge clk); #1;
        collecting = 1'b0;
        check_val($sformatf("seg%0d_nready", seg_num), 64'(obs_q.size()), 64'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int k = 0; k < n; k++) begin
            t = $sformatf("seg%0d_ev%0d", seg_num, k);
            check_val({t, "_time"}, 64'(obs_q[k].idx), 64'(exp_q[k].idx));
            check_val({t, "_d1"},   64'(obs_q[k].d1),  64'(exp_q[k].d1));
            check_val({t, "_d2"},   64'(obs_q[k].d2),  64'(exp_q[k].d2));
            check_val({t, "_fin"},  64'(obs_q[k].fin), 64'(exp_q[k].fin));
            check_val({t, "_fs"},   64'(obs_q[k].fs),  64'(exp_q[k].fs));
            check_val({t, "_to"},   64'(obs_q[k].to),  64'(exp_q[k].to));
        end
        ref_q.delete();
        fb_q.delete();
        seg_num++;
    endtask

    initial begin
        int np;
        int p;
        int m;
        int lag;
        int lag2;

        // Period 31, feedback lag 10
        apply_reset();
        add_idle(2);
        repeat (4) add_period(31, 10, -1);
        add_idle(12);
        run_segment();

        // Lag 25, double feedback pulse, aligned edges, feedback held low
        apply_reset();
        add_idle(2);
        repeat (2) add_period(31, 25, -1);
        add_period(31, 10, 20);
        repeat (2) add_period(31, 0, -1);
        repeat (2) add_period(31, -1, -1);
        add_idle(12);
        run_segment();

        // Reference stops long enough to time out, then restarts
        apply_reset();
        add_idle(2);
        repeat (2) add_period(31, 10, -1);
        add_idle(530);
        repeat (3) add_period(20, 5, -1);
        add_idle(12);
        run_segment();

        // Leave the design mid-S_FB; the next reset must clear it without a ready
        apply_reset();
        add_idle(2);
        repeat (3) add_period(31, 10, -1);
        for (int i = 0; i < 20; i++) begin
            ref_q.push_back(i < 15);
            fb_q.push_back(i >= 10 && i < 12);
        end
        run_segment();

        // Randomized periods and feedback placements
        for (int s = 0; s < 8; s++) begin
            apply_reset();
            add_idle(2);
            np = $urandom_range(3, 6);
            for (int k = 0; k < np; k++) begin
                p    = $urandom_range(8, 60);
                m    = $urandom_range(0, 3);
                lag  = -1;
                lag2 = -1;
                if (m == 1 || m == 2) lag = $urandom_range(1, p - 3);
                if (m == 3) lag = 0;
                if (m == 2 && lag + 4 <= p - 3) lag2 = $urandom_range(lag + 4, p - 3);
                add_period(p, lag, lag2);
            end
            add_idle(12);
            run_segment();
        end

        apply_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
